// File: rtl/hb_watchdog_pkg.sv
// Shared types and constants for the heartbeat watchdog: FSM state encoding
// (also used by benches to decode state_o) and default timing parameters.
package hb_watchdog_pkg;

    typedef enum logic [1:0] {
        HB_IDLE  = 2'd0,
        HB_ARMED = 2'd1,
        HB_TRACK = 2'd2,
        HB_FAULT = 2'd3
    } hb_state_t;

    localparam int HB_PERIOD_DEF   = 1000;
    localparam int HB_TOL_DEF      = 16;
    localparam int HB_MAX_MISS_DEF = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_TRACK = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

endpackage

// File: rtl/hb_watchdog.sv
// Heartbeat receiver: checks beat spacing against PERIOD_CYCLES +/- TOLERANCE and
// latches a sticky fault after MAX_MISS consecutive violations. HB_WATCHDOG_STATS_EN adds beat statistics.
module hb_watchdog
    import hb_watchdog_pkg::*;
#(
    parameter int PERIOD_CYCLES = HB_PERIOD_DEF,
    parameter int TOLERANCE     = HB_TOL_DEF,
    parameter int MAX_MISS      = HB_MAX_MISS_DEF,
    localparam int TIMER_W      = $clog2(PERIOD_CYCLES + TOLERANCE + 1),
    localparam int MISS_W       = $clog2(MAX_MISS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic              hb_i,
    input  logic              clear_i,
    output logic              alive_o,
    output logic              early_o,
    output logic              miss_o,
    output logic [MISS_W-1:0] miss_cnt_o,
    output logic              fault_o,
    output logic [1:0]        state_o
`ifdef HB_WATCHDOG_STATS_EN
    ,
    output logic [15:0]       beat_cnt_o,
    output logic [TIMER_W-1:0] last_interval_o
`endif
);

    localparam logic [TIMER_W-1:0] WIN_LO    = TIMER_W'(PERIOD_CYCLES - TOLERANCE);
    localparam logic [TIMER_W-1:0] WIN_HI    = TIMER_W'(PERIOD_CYCLES + TOLERANCE);
    localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);
    localparam logic [MISS_W-1:0]  MISS_MAX  = MISS_W'(MAX_MISS);

    logic [1:0]         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [MISS_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic [MISS_W-1:0]  miss_inc;
    logic               early_q, early_d;
    logic               miss_q, miss_d;
    logic               fault_q, fault_d;
    logic               bump;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        miss_cnt_d = miss_cnt_q;
        early_d    = 1'b0;
        miss_d     = 1'b0;
        fault_d    = fault_q;
        bump       = 1'b0;
        miss_inc   = (miss_cnt_q == MISS_MAX) ? miss_cnt_q : miss_cnt_q + MISS_W'(1);

        if (clear_i) begin
            state_d    = ST_IDLE;
            timer_d    = '0;
            miss_cnt_d = '0;
            fault_d    = 1'b0;
        end else if (state_q == ST_FAULT) begin
            state_d = ST_FAULT;
        end else if (!enable_i) begin
            state_d    = ST_IDLE;
            timer_d    = '0;
            miss_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_ARMED;
                    timer_d    = '0;
                    miss_cnt_d = '0;
                end
                ST_ARMED: begin
                    if (hb_i) begin
                        state_d = ST_TRACK;
                        timer_d = TIMER_ONE;
                    end
                end
                ST_TRACK: begin
                    // A real beat counts its own cycle as t=0, so the timer restarts at 1;
                    // a virtual beat (timeout) has no such cycle and restarts at 0.
                    if (hb_i) begin
                        timer_d = TIMER_ONE;
                        if (timer_q < WIN_LO) begin
                            early_d = 1'b1;
                            bump    = 1'b1;
                        end else begin
                            miss_cnt_d = '0;
                        end
                    end else if (timer_q == WIN_HI) begin
                        miss_d  = 1'b1;
                        timer_d = '0;
                        bump    = 1'b1;
                    end else begin
                        timer_d = timer_q + TIMER_ONE;
                    end
                    if (bump) begin
                        miss_cnt_d = miss_inc;
                        if (miss_inc == MISS_MAX) begin
                            state_d = ST_FAULT;
                            fault_d = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            miss_cnt_q <= '0;
            early_q    <= 1'b0;
            miss_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            miss_cnt_q <= miss_cnt_d;
            early_q    <= early_d;
            miss_q     <= miss_d;
            fault_q    <= fault_d;
        end
    end

    assign alive_o    = (state_q == ST_TRACK) && (miss_cnt_q == '0);
    assign early_o    = early_q;
    assign miss_o     = miss_q;
    assign miss_cnt_o = miss_cnt_q;
    assign fault_o    = fault_q;
    assign state_o    = state_q;

`ifdef HB_WATCHDOG_STATS_EN
    logic [15:0]        beat_cnt_q, beat_cnt_d;
    logic [TIMER_W-1:0] last_interval_q, last_interval_d;
    logic               valid_beat;

    always_comb begin
        valid_beat      = !clear_i && enable_i && (state_q == ST_TRACK) && hb_i && (timer_q >= WIN_LO);
        beat_cnt_d      = beat_cnt_q;
        last_interval_d = last_interval_q;
        if (clear_i) begin
            beat_cnt_d      = '0;
            last_interval_d = '0;
        end else if (valid_beat) begin
            if (beat_cnt_q != 16'hFFFF) beat_cnt_d = beat_cnt_q + 16'd1;
            last_interval_d = timer_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q      <= '0;
            last_interval_q <= '0;
        end else begin
            beat_cnt_q      <= beat_cnt_d;
            last_interval_q <= last_interval_d;
        end
    end

    assign beat_cnt_o      = beat_cnt_q;
    assign last_interval_o = last_interval_q;
`endif

endmodule
